// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 operation encodings and the control FSM state type.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_addsub.sv
// W-bit adder/subtractor shared by the shift-add multiply step and the
// restoring-divide trial subtraction; purely combinational.
module muldiv_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] sum
);

  logic [W-1:0] y_eff;

  always_comb begin
    y_eff = sub ? ~y : y;
    sum   = x + y_eff + {{(W-1){1'b0}}, sub};
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one bit per clock, XLEN iterations per op,
// divide-by-zero and signed overflow resolved on the accepting edge.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state;
  logic [2:0]          op_q;
  logic                neg_q;
  logic [XLEN-1:0]     opnd_q;
  logic [2*XLEN-1:0]   acc;
  logic [CW-1:0]       cnt;
  logic [XLEN-1:0]     result_q;

  // Request decode
  logic            is_div_in, signed_a, signed_b, sa, sb, neg_in, special;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  always_comb begin
    is_div_in   = op[2];
    signed_a    = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    signed_b    = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    sa          = signed_a & a[XLEN-1];
    sb          = signed_b & b[XLEN-1];
    mag_a       = sa ? -a : a;
    mag_b       = sb ? -b : b;
    // Quotient and product negate on sign mismatch; remainder follows the dividend.
    neg_in      = (op == OP_REM) ? sa : (sa ^ sb);
    special     = 1'b0;
    special_res = '0;
    if (is_div_in && (b == '0)) begin
      special     = 1'b1;
      special_res = op[1] ? a : '1;
    end else if (((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1)) begin
      special     = 1'b1;
      special_res = op[1] ? '0 : a;
    end
  end

  // One iteration of shift-add or restoring divide
  logic [XLEN-1:0]   hi, lo;
  logic              is_div_q;
  logic [XLEN:0]     as_x, as_y, as_sum;
  logic [2*XLEN-1:0] acc_next, prod;
  logic [XLEN-1:0]   quo, rem, final_res;

  muldiv_addsub #(.W(XLEN + 1)) u_addsub (
    .x   (as_x),
    .y   (as_y),
    .sub (is_div_q),
    .sum (as_sum)
  );

  always_comb begin
    hi       = acc[2*XLEN-1:XLEN];
    lo       = acc[XLEN-1:0];
    is_div_q = op_q[2];
    as_x     = is_div_q ? {hi, lo[XLEN-1]} : {1'b0, hi};
    as_y     = {1'b0, opnd_q};
    if (is_div_q) begin
      // Top bit of the trial difference is the borrow: clear means divisor fits.
      if (!as_sum[XLEN])
        acc_next = {as_sum[XLEN-1:0], lo[XLEN-2:0], 1'b1};
      else
        acc_next = {hi[XLEN-2:0], lo[XLEN-1], lo[XLEN-2:0], 1'b0};
    end else begin
      if (lo[0])
        acc_next = {as_sum, lo[XLEN-1:1]};
      else
        acc_next = {1'b0, hi, lo[XLEN-1:1]};
    end
    prod = neg_q ? -acc_next : acc_next;
    quo  = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    rem  = neg_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    if (is_div_q)
      final_res = op_q[1] ? rem : quo;
    else
      final_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc      <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(XLEN - 1)) begin
              state    <= DONE;
              result_q <= final_res;
            end
          end
        end
        default: begin
          if (flush) begin
            state <= IDLE;
          end else if (start) begin
            op_q   <= op;
            neg_q  <= neg_in;
            cnt    <= '0;
            // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
            opnd_q <= is_div_in ? mag_b : mag_a;
            acc    <= {{XLEN{1'b0}}, (is_div_in ? mag_a : mag_b)};
            if (special) begin
              state    <= DONE;
              result_q <= special_res;
            end else begin
              state <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign ready  = (state != CALC);
  assign done   = (state == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (XLEN=32) with hand-computed results.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        ready, done;
  logic [31:0] result;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
    .a(a), .b(b), .ready(ready), .done(done), .result(result)
  );

  // Issues one request from idle; edges counts rising edges up to done, the accepting edge being 1.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int edges, output logic rdy1);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; op = OP_MULHU;
    rdy1  = ready;
    edges = 1;
    while (!done && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    res = result;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset: ready=%b done=%b result=%h, required 1 0 00000000", ready, done, result);
    end
  endtask

  task automatic test_mul;
    logic [2:0]  ops[4] = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU};
    logic [31:0] va[4]  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] vb[4]  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex[4]  = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] res;
    int edges;
    logic rdy1;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], va[i], vb[i], res, edges, rdy1);
      checks++;
      if (res !== ex[i] || edges != 33 || rdy1 !== 1'b0) begin
        errors++;
        $display("FAIL mul[%0d]: result=%h edges=%0d ready_in_calc=%b, required %h 33 0",
                 i, res, edges, rdy1, ex[i]);
      end
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops[4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
    logic [31:0] va[4]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] vb[4]  = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] ex[4]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    logic [31:0] res;
    int edges;
    logic rdy1;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], va[i], vb[i], res, edges, rdy1);
      checks++;
      if (res !== ex[i] || edges != 33) begin
        errors++;
        $display("FAIL div[%0d]: result=%h edges=%0d, required %h 33", i, res, edges, ex[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || result !== 32'd2) begin
      errors++;
      $display("FAIL done_pulse: done=%b result=%h, required 0 00000002", done, result);
    end
  endtask

  task automatic test_special;
    logic [2:0]  ops[4] = '{OP_DIV, OP_REMU, OP_DIV, OP_REM};
    logic [31:0] va[4]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] vb[4]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex[4]  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    logic [31:0] res;
    int edges;
    logic rdy1;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], va[i], vb[i], res, edges, rdy1);
      checks++;
      if (res !== ex[i] || edges != 1) begin
        errors++;
        $display("FAIL special[%0d]: result=%h edges=%0d, required %h 1", i, res, edges, ex[i]);
      end
    end
  endtask

  task automatic test_flush;
    logic [31:0] res;
    int edges, nd;
    logic rdy1;
    run_op(OP_MUL, 32'd5, 32'd5, res, edges, rdy1);
    @(negedge clk);
    op = OP_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || result !== 32'd25) begin
      errors++;
      $display("FAIL flush_calc: ready=%b done=%b result=%h, required 1 0 00000019", ready, done, result);
    end
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    checks++;
    if (nd != 0 || result !== 32'd25) begin
      errors++;
      $display("FAIL flush_no_done: done_count=%0d result=%h, required 0 00000019", nd, result);
    end
    @(negedge clk);
    op = OP_MUL; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: ready=%b done=%b, required 1 0", ready, done);
    end
    run_op(OP_MUL, 32'd3, 32'd4, res, edges, rdy1);
    checks++;
    if (res !== 32'd12 || edges != 33) begin
      errors++;
      $display("FAIL flush_recover: result=%h edges=%0d, required 0000000c 33", res, edges);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0]  ops[3] = '{OP_MUL, OP_DIVU, OP_REM};
    logic [31:0] va[3]  = '{32'd5, 32'd100, 32'hFFFF_FFF9};
    logic [31:0] vb[3]  = '{32'd6, 32'd7, 32'd2};
    logic [31:0] ex[3]  = '{32'd30, 32'd14, 32'hFFFF_FFFF};
    int idx, nd;
    logic acc, dn_at_acc;
    idx = 0; nd = 0;
    @(negedge clk);
    op = ops[0]; a = va[0]; b = vb[0]; start = 1'b1;
    for (int c = 0; c < 150; c++) begin
      acc = ready && start;
      dn_at_acc = done;
      @(posedge clk); #1;
      if (done) begin
        if (nd < 3) begin
          checks++;
          if (result !== ex[nd]) begin
            errors++;
            $display("FAIL b2b_result[%0d]: result=%h, required %h", nd, result, ex[nd]);
          end
        end
        nd++;
      end
      if (acc) begin
        if (idx > 0) begin
          checks++;
          if (dn_at_acc !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept_in_done[%0d]: done=%b, required 1", idx, dn_at_acc);
          end
        end
        idx++;
        if (idx < 3) begin
          op = ops[idx]; a = va[idx]; b = vb[idx];
        end else begin
          start = 1'b0;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (nd != 3 || idx != 3) begin
      errors++;
      $display("FAIL b2b_count: done_count=%0d accepted=%0d, required 3 3", nd, idx);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] res;
    int edges, nd;
    logic rdy1;
    run_op(OP_MUL, 32'd5, 32'd5, res, edges, rdy1);
    @(negedge clk);
    op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: ready=%b done=%b result=%h, required 1 0 00000000", ready, done, result);
    end
    #1 rst = 1'b0;
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL reset_abort: done_count=%0d, required 0", nd);
    end
    run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, res, edges, rdy1);
    checks++;
    if (res !== 32'hFFFF_FFF2 || edges != 33) begin
      errors++;
      $display("FAIL reset_recover: result=%h edges=%0d, required fffffff2 33", res, edges);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = OP_MUL; a = '0; b = '0;
    repeat (2) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
